// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state type and NOP encoding for the hazard sequencer
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} hz_state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: enable-increment counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, taken branches and slow data memory
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH              = 32,
  parameter int TIMEOUT_CYCLES         = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs2D_i,
  input  logic                              useRs1D_i,
  input  logic                              useRs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3E_i,
  input  logic                              regWriteE_i,
  input  logic                              resultSrcE_i,
  input  logic                              branchTakenE_i,
  input  logic                              memReqM_i,
  input  logic                              memAckM_i,
  output logic                              fetchEn_o,
  output logic                              decodeEn_o,
  output logic                              execEn_o,
  output logic                              memEn_o,
  output logic                              flushD_o,
  output logic                              flushE_o,
  output logic                              memTimeout_o,
  output logic [CNT_WIDTH-1:0]              stallCnt_o,
  output logic [CNT_WIDTH-1:0]              flushCnt_o
);
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  hz_state_t state;
  logic [WW-1:0] wait_cnt;
  logic load_use, busy, frozen, flush, stall;
  assign load_use = resultSrcE_i && regWriteE_i && AD3E_i != '0 &&
                    ((useRs1D_i && rs1D_i == AD3E_i) || (useRs2D_i && rs2D_i == AD3E_i));
  assign busy   = memReqM_i && !memAckM_i;
  assign frozen = state == HALT || busy;
  assign flush  = !frozen && branchTakenE_i;
  assign stall  = !frozen && !branchTakenE_i && load_use;
  // Reset forces every register to hold a bubble until rst_n releases.
  assign fetchEn_o  = rst_n && !frozen && !stall;
  assign decodeEn_o = rst_n && !frozen && !stall;
  assign execEn_o   = rst_n && !frozen;
  assign memEn_o    = rst_n && !frozen;
  assign flushD_o   = !rst_n || flush;
  assign flushE_o   = !rst_n || flush || stall;
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      memTimeout_o <= 1'b0;
    end else if (state == RUN) begin
      if (busy) begin
        state    <= MEM_WAIT;
        wait_cnt <= '0;
      end
    end else if (state == MEM_WAIT) begin
      if (memAckM_i) state <= RUN;
      else if (TIMEOUT_CYCLES != 0 && wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
        state        <= HALT;
        memTimeout_o <= 1'b1;
      end else wait_cnt <= wait_cnt + WW'(1);
    end
  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!fetchEn_o),
    .cnt  (stallCnt_o)
  );
  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (flush),
    .cnt  (flushCnt_o)
  );
endmodule
